peripheral_spram_wb_master: RTL and testbench
=============================================

# peripheral_spram_wb_master

Wishbone burst master that sits directly upstream of the single-port RAM Wishbone slave and feeds it. It accepts simple read/write commands (start address plus beat count), buffers write data in a small FIFO, and issues classic or incrementing linear bursts (CTI/BTE) on the Wishbone bus. Read data is returned as a non-stallable stream, and each command ends with a one-cycle completion pulse.

## Interface
- DW, 32: data width; must be 32 (4 byte lanes).
- AW, 8: Wishbone byte-address width.
- MAX_BURST, 16: maximum beats per command; power of two, 2..256.
- LW, $clog2(MAX_BURST): width of the length field.

Ports:
- wb_clk_i in 1: clock.
- wb_rst_i in 1: reset, asynchronous, active-low.
- cmd_valid_i in 1: command request.
- cmd_ready_o out 1: command accepted when high with cmd_valid_i.
- cmd_we_i in 1: 1 = write, 0 = read.
- cmd_adr_i in AW: start byte address; bits [1:0] ignored (forced 0).
- cmd_len_i in LW: beats minus 1.
- wdat_valid_i in 1: write-data word valid.
- wdat_ready_o out 1: write FIFO not full.
- wdat_dat_i in DW: write data.
- wdat_sel_i in 4: byte enables.
- rdat_valid_o out 1: read word valid, one cycle, no backpressure.
- rdat_dat_o out DW: read word.
- rdat_last_o out 1: last beat of read command.
- done_o out 1: command complete pulse.
- err_o out 1: with done_o, command terminated by wb_err_i.
- wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o[2:0], wb_bte_o[1:0], wb_cyc_o, wb_stb_o: out, Wishbone master outputs.
- wb_dat_i in DW, wb_ack_i in 1, wb_err_i in 1: Wishbone master inputs.

## Operation
- FSM: IDLE, FILL, BURST, DONE.
- IDLE: cmd_ready_o=1. On handshake, latch we, adr (low 2 bits 0), remaining=cmd_len_i+1. Read -> BURST; write -> FILL.
- FILL: wait until FIFO count >= remaining, then -> BURST. Holds the whole burst in the FIFO so stb is never dropped mid-burst.
- BURST: cyc=stb=1; wb_adr_o = current address; wb_we_o = latched we; wb_bte_o = 2'b00 (linear).
- wb_cti_o: 000 when the command has one beat; otherwise 010 while remaining>1 and 111 when remaining==1.
- Writes: wb_dat_o/wb_sel_o come from the FIFO head. Reads: wb_sel_o = 4'hF.
- On wb_ack_i: address += 4 (wraps modulo 2^AW); remaining -= 1; pop FIFO (write) or pulse rdat_valid_o with wb_dat_i (read). rdat_last_o is set on the final beat.
- On the final ack, or on wb_err_i (see Configuration): -> DONE.
- DONE: cyc=stb=0; done_o=1 for one cycle; -> IDLE.
- wdat_ready_o = FIFO not full, in any state, so prefill is allowed. Push when wdat_valid_i & wdat_ready_o.
- A simultaneous push and pop leaves the count unchanged.

## Timing
- Reset values: all outputs 0 except cmd_ready_o=1 and wdat_ready_o=1. FSM is IDLE, FIFO is empty.
- Reset asserted mid-burst: cyc/stb drop asynchronously, the FIFO is flushed, and the in-flight command is lost with no done_o.
- Read of N beats accepted at cycle T: stb high from T+1; with the RAM slave, acks at T+2..T+N+1; done_o at T+N+2.
- Write with data prefilled: same as read. Otherwise BURST starts the cycle after the FIFO count reaches N.
- rdat_valid_o/rdat_dat_o are registered: one cycle after the ack.
- wb_adr_o changes only on ack, so every beat's address is always correct on the bus.

## Configuration
- PERIPHERAL_SPRAM_WB_MASTER_ERR_EN defined:
  - wb_err_i is treated as a beat termination.
  - The master drops cyc/stb, flushes the remaining beats of this command from the FIFO, and pulses done_o together with err_o.
- Not defined: wb_err_i is ignored and err_o is tied to 0.

## Structure
- Shared package peripheral_spram_wb_pkg holds:
  - CTI constants (CLASSIC 000, INC_BURST 010, END_OF_BURST 111);
  - BTE constants (LINEAR 00);
  - the FSM state enum.
- The slave reuses the same CTI/BTE constants.
- One sub-module: peripheral_spram_wb_master_fifo, a synchronous FIFO of depth MAX_BURST and width DW+4 with count output, flush, full and empty.

## Test plan
- Single read, cmd_adr=0x10, len=0 -> cti=000, adr=0x10, one rdat_valid with rdat_last=1, done_o 3 cycles after accept.
- Read burst, adr=0x00, len=3 -> adr 0x00/04/08/0C, cti 010,010,010,111; 4 rdat words, last flagged; done at T+6.
- Write burst of 4 with data prefilled, sel=4'b0011 on beat 2 -> beats match FIFO order and sel; read-back shows only the low half updated.
- Write with data trickled in 1 word per 3 cycles -> stb stays low until 4 words are buffered, then 4 back-to-back acks.
- Address wrap: adr=0xFC, len=1 -> beats at 0xFC then 0x00.
- Async reset mid read burst (after 2 acks) -> cyc/stb=0 immediately, no done_o; the next command completes normally. With ERR_EN, wb_err_i on beat 2 -> done_o and err_o in the same cycle, FIFO empty.

Source files
------------

// File: rtl/peripheral_spram_wb_pkg.sv
// peripheral_spram_wb_pkg: Wishbone CTI/BTE codes shared by the SPRAM slave and burst master, plus the master FSM states
package peripheral_spram_wb_pkg;
    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_INC_BURST    = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;
    localparam logic [1:0] BTE_LINEAR       = 2'b00;
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_BURST, ST_DONE} master_state_t;
endpackage

// File: rtl/peripheral_spram_wb_master_fifo.sv
// peripheral_spram_wb_master_fifo: synchronous write-data FIFO with occupancy count and flush
// Ports: wb_clk_i/wb_rst_i (async active-low); push/din in; pop/dout (head, show-ahead) out;
//        flush empties the FIFO (a concurrent push is kept); count/full/empty status.
module peripheral_spram_wb_master_fifo #(
    parameter int W = 36,
    parameter int DEPTH = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_idx;
    logic do_push, do_pop;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign wr_idx = flush ? '0 : wr_ptr;
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_idx] <= din;
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= PW'(do_push);
            rd_ptr <= '0;
            count <= CW'(do_push);
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    assign dout = mem[rd_ptr];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/peripheral_spram_wb_master.sv
// peripheral_spram_wb_master: Wishbone burst master feeding the SPRAM slave from read/write commands
// Ports: cmd_* command handshake (start byte address, beats-1); wdat_* write-data stream into FIFO;
//        rdat_* registered read stream (no backpressure); done_o/err_o completion pulse;
//        wb_* Wishbone master bus. Clock wb_clk_i, async active-low reset wb_rst_i.
// Option: define PERIPHERAL_SPRAM_WB_MASTER_ERR_EN to terminate a command on wb_err_i.
module peripheral_spram_wb_master
    import peripheral_spram_wb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 8,
    parameter int MAX_BURST = 16,
    parameter int LW = $clog2(MAX_BURST)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [LW-1:0] cmd_len_i,
    input  logic          wdat_valid_i,
    output logic          wdat_ready_o,
    input  logic [DW-1:0] wdat_dat_i,
    input  logic [3:0]    wdat_sel_i,
    output logic          rdat_valid_o,
    output logic [DW-1:0] rdat_dat_o,
    output logic          rdat_last_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);
    localparam int CW = LW + 1;
    master_state_t state, state_nx;
    logic we_q, single_q;
    logic [AW-1:0] adr_q;
    logic [CW-1:0] rem_q, fifo_cnt;
    logic [DW+3:0] fifo_head;
    logic fifo_full, fifo_empty, accept, in_burst, err_hit, beat, last_beat;
    logic [1:0] unused_adr;
    assign unused_adr = cmd_adr_i[1:0];
    assign accept = cmd_valid_i & cmd_ready_o;
    assign in_burst = state == ST_BURST;
`ifdef PERIPHERAL_SPRAM_WB_MASTER_ERR_EN
    logic err_q;
    assign err_hit = in_burst & wb_err_i;
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) err_q <= 1'b0;
        else err_q <= err_hit;
    end
    assign err_o = done_o & err_q;
`else
    logic unused_err;
    assign unused_err = wb_err_i;
    assign err_hit = 1'b0;
    assign err_o = 1'b0;
`endif
    assign beat = in_burst & wb_ack_i & ~err_hit;
    assign last_beat = beat & (rem_q == CW'(1));
    // A write whose data is already buffered skips FILL so it issues as early as a read.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = (!cmd_we_i || fifo_cnt > CW'(cmd_len_i)) ? ST_BURST : ST_FILL;
            ST_FILL:  if (fifo_cnt >= rem_q) state_nx = ST_BURST;
            ST_BURST: if (last_beat || err_hit) state_nx = ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state <= ST_IDLE;
            we_q <= 1'b0;
            single_q <= 1'b0;
            adr_q <= '0;
            rem_q <= '0;
            rdat_valid_o <= 1'b0;
            rdat_last_o <= 1'b0;
            rdat_dat_o <= '0;
        end else begin
            state <= state_nx;
            rdat_valid_o <= beat & ~we_q;
            rdat_last_o <= last_beat & ~we_q;
            if (beat & ~we_q) rdat_dat_o <= wb_dat_i;
            if (accept) begin
                we_q <= cmd_we_i;
                single_q <= cmd_len_i == '0;
                adr_q <= {cmd_adr_i[AW-1:2], 2'b00};
                rem_q <= CW'(cmd_len_i) + CW'(1);
            end else if (beat) begin
                adr_q <= adr_q + AW'(4);
                rem_q <= rem_q - CW'(1);
            end
        end
    end
    assign cmd_ready_o = state == ST_IDLE;
    assign done_o = state == ST_DONE;
    assign wdat_ready_o = ~fifo_full;
    assign wb_cyc_o = in_burst;
    assign wb_stb_o = in_burst;
    assign wb_we_o = in_burst & we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = wb_we_o ? fifo_head[DW-1:0] : '0;
    assign wb_sel_o = !in_burst ? 4'h0 : we_q ? fifo_head[DW+3:DW] : 4'hF;
    assign wb_cti_o = !in_burst || single_q ? CTI_CLASSIC : rem_q == CW'(1) ? CTI_END_OF_BURST : CTI_INC_BURST;
    assign wb_bte_o = BTE_LINEAR;
    // On an error the rest of a write's data is discarded so the next command starts clean.
    peripheral_spram_wb_master_fifo #(.W(DW + 4), .DEPTH(MAX_BURST)) u_fifo (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .flush(err_hit & we_q),
        .push(wdat_valid_i & ~fifo_full),
        .din({wdat_sel_i, wdat_dat_i}),
        .pop(beat & we_q & ~fifo_empty),
        .dout(fifo_head),
        .count(fifo_cnt),
        .full(fifo_full),
        .empty(fifo_empty)
    );
endmodule

// File: tb/tb_peripheral_spram_wb_master.sv
// tb_peripheral_spram_wb_master: directed checks of the burst master against a small SPRAM slave model
module tb_peripheral_spram_wb_master;
    logic wb_clk_i = 1'b0, wb_rst_i = 1'b0;
    logic cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
    logic [7:0] cmd_adr_i = '0;
    logic [3:0] cmd_len_i = '0;
    logic wdat_valid_i = 1'b0;
    logic [31:0] wdat_dat_i = '0;
    logic [3:0] wdat_sel_i = '0;
    logic cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_last_o, done_o, err_o;
    logic [31:0] rdat_dat_o, wb_dat_o, wb_dat_i;
    logic [7:0] wb_adr_o;
    logic [3:0] wb_sel_o;
    logic [2:0] wb_cti_o;
    logic [1:0] wb_bte_o;
    logic wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    int errors = 0, checks = 0;
    always #5 wb_clk_i = ~wb_clk_i;

    peripheral_spram_wb_master dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
        .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
        .wdat_dat_i(wdat_dat_i), .wdat_sel_i(wdat_sel_i),
        .rdat_valid_o(rdat_valid_o), .rdat_dat_o(rdat_dat_o), .rdat_last_o(rdat_last_o),
        .done_o(done_o), .err_o(err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    // slave model: ack one cycle after stb, then every cycle until the end-of-burst beat
    logic [31:0] mem [64];
    logic ack_q = 1'b0, init_done = 1'b0, hit;
    int sl_cnt = 0, err_at = -1;
    assign hit = ack_q & wb_cyc_o & wb_stb_o;
    assign wb_ack_i = hit & (sl_cnt != err_at);
    assign wb_err_i = hit & (sl_cnt == err_at);
    assign wb_dat_i = mem[wb_adr_o[7:2]];
    always @(posedge wb_clk_i) begin
        ack_q <= wb_cyc_o & wb_stb_o & ~(hit & (wb_cti_o == 3'b000 || wb_cti_o == 3'b111));
        sl_cnt <= wb_cyc_o ? sl_cnt + int'(hit) : 0;
        init_done <= 1'b1;
        if (!init_done) for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        else if (wb_ack_i && wb_we_o)
            for (int i = 0; i < 4; i++) if (wb_sel_o[i]) mem[wb_adr_o[7:2]][8*i +: 8] <= wb_dat_o[8*i +: 8];
    end

    // bus / stream monitor, sampled mid-cycle
    logic [7:0] b_adr [128];
    logic [2:0] b_cti [128];
    logic [31:0] b_dat [128];
    logic [3:0] b_sel [128];
    int b_cyc [128];
    logic [31:0] r_dat [128];
    logic r_last [128];
    int nb = 0, nr = 0, nd = 0, ns = 0, done_cyc = 0, stb_rise = 0, cyc_n = 0, t_acc = 0;
    logic done_err = 1'b0, stb_d = 1'b0;
    always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;
    always @(negedge wb_clk_i) begin
        stb_d <= wb_stb_o;
        if (wb_stb_o && !stb_d) begin
            stb_rise <= cyc_n;
            ns <= ns + 1;
        end
        if (wb_ack_i && nb < 128) begin
            b_adr[nb] <= wb_adr_o;
            b_cti[nb] <= wb_cti_o;
            b_dat[nb] <= wb_dat_o;
            b_sel[nb] <= wb_sel_o;
            b_cyc[nb] <= cyc_n;
            nb <= nb + 1;
        end
        if (rdat_valid_o && nr < 128) begin
            r_dat[nr] <= rdat_dat_o;
            r_last[nr] <= rdat_last_o;
            nr <= nr + 1;
        end
        if (done_o) begin
            done_cyc <= cyc_n;
            done_err <= err_o;
            nd <= nd + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] s);
        wdat_valid_i = 1'b1;
        wdat_dat_i = d;
        wdat_sel_i = s;
        @(posedge wb_clk_i);
        #1 wdat_valid_i = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [7:0] adr, input logic [3:0] len);
        int d0 = nd;
        cmd_valid_i = 1'b1;
        cmd_we_i = we;
        cmd_adr_i = adr;
        cmd_len_i = len;
        t_acc = cyc_n;
        @(posedge wb_clk_i);
        #1 cmd_valid_i = 1'b0;
        for (int i = 0; i < 100 && nd == d0; i++) begin
            @(negedge wb_clk_i);
            #1;
        end
        chk("done_seen", nd - d0, 1);
        @(posedge wb_clk_i);
        #1;
    endtask

    logic [31:0] wd [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic [3:0] ws [4] = '{4'hF, 4'h3, 4'hF, 4'hF};
    logic [31:0] rb [4] = '{32'h1111_1111, 32'hA000_2222, 32'h3333_3333, 32'h4444_4444};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0, r0, s0, d0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_ready", {cmd_ready_o, wdat_ready_o}, 2'b11);
        chk("rst_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, done_o, err_o, rdat_valid_o, rdat_last_o}, 0);
        chk("rst_bus", {wb_adr_o, wb_sel_o, wb_cti_o, wb_bte_o, wb_dat_o}, 0);
        chk("rst_rdat", rdat_dat_o, 0);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        // single read
        b0 = nb; r0 = nr;
        issue(1'b0, 8'h10, 4'd0);
        chk("rd1_nbeat", nb - b0, 1);
        chk("rd1_adr", b_adr[b0], 8'h10);
        chk("rd1_cti", b_cti[b0], 3'b000);
        chk("rd1_stb_at", stb_rise - t_acc, 1);
        chk("rd1_ack_at", b_cyc[b0] - t_acc, 2);
        chk("rd1_done_at", done_cyc - t_acc, 3);
        chk("rd1_nrdat", nr - r0, 1);
        chk("rd1_rdat", {r_last[r0], r_dat[r0]}, {1'b1, 32'hA000_0004});
        chk("rd1_err", done_err, 0);
        // read burst of 4
        b0 = nb; r0 = nr;
        issue(1'b0, 8'h00, 4'd3);
        for (int k = 0; k < 4; k++) begin
            chk("rd4_adr", b_adr[b0+k], 8'(4 * k));
            chk("rd4_cti", b_cti[b0+k], k == 3 ? 3'b111 : 3'b010);
            chk("rd4_rdat", {r_last[r0+k], r_dat[r0+k]}, {k == 3, 32'hA000_0000 + 32'(k)});
        end
        chk("rd4_done_at", done_cyc - t_acc, 6);
        // prefilled write burst, partial byte enables on beat 2
        for (int k = 0; k < 4; k++) push(wd[k], ws[k]);
        b0 = nb;
        issue(1'b1, 8'h20, 4'd3);
        chk("wr4_stb_at", stb_rise - t_acc, 1);
        chk("wr4_done_at", done_cyc - t_acc, 6);
        for (int k = 0; k < 4; k++) begin
            chk("wr4_adr", b_adr[b0+k], 8'h20 + 8'(4 * k));
            chk("wr4_data", {b_sel[b0+k], b_dat[b0+k]}, {ws[k], wd[k]});
        end
        r0 = nr;
        issue(1'b0, 8'h20, 4'd3);
        for (int k = 0; k < 4; k++) chk("wr4_readback", r_dat[r0+k], rb[k]);
        // trickled write: one word every 3 cycles
        b0 = nb; s0 = ns;
        fork
            issue(1'b1, 8'h30, 4'd3);
            for (int k = 0; k < 4; k++) begin
                push(32'h5000_0000 + 32'(k), 4'hF);
                if (k < 3) begin
                    repeat (2) @(posedge wb_clk_i);
                    #1;
                end
            end
        join
        chk("tr_nstb", ns - s0, 1);
        chk("tr_stb_at", stb_rise - t_acc, 11);
        chk("tr_ack0_at", b_cyc[b0] - t_acc, 12);
        chk("tr_ack3_at", b_cyc[b0+3] - t_acc, 15);
        chk("tr_done_at", done_cyc - t_acc, 16);
        for (int k = 0; k < 4; k++) chk("tr_data", b_dat[b0+k], 32'h5000_0000 + 32'(k));
        // address wrap, low address bits ignored
        b0 = nb; r0 = nr;
        issue(1'b0, 8'hFD, 4'd1);
        chk("wrap_adr0", b_adr[b0], 8'hFC);
        chk("wrap_adr1", b_adr[b0+1], 8'h00);
        chk("wrap_cti", {b_cti[b0], b_cti[b0+1]}, {3'b010, 3'b111});
        chk("wrap_rdat0", {r_last[r0], r_dat[r0]}, {1'b0, 32'hA000_003F});
        chk("wrap_rdat1", {r_last[r0+1], r_dat[r0+1]}, {1'b1, 32'hA000_0000});
        // async reset mid read burst, with a stale word sitting in the FIFO
        push(32'hDEAD_BEEF, 4'hF);
        b0 = nb; d0 = nd;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 8'h00; cmd_len_i = 4'd3;
        @(posedge wb_clk_i);
        #1 cmd_valid_i = 1'b0;
        for (int i = 0; i < 20 && nb - b0 < 2; i++) begin
            @(negedge wb_clk_i);
            #1;
        end
        chk("mid_two_acks", nb - b0, 2);
        @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        #1 chk("mid_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1 chk("mid_no_done", nd - d0, 0);
        b0 = nb; s0 = ns;
        fork
            issue(1'b1, 8'h40, 4'd0);
            begin
                repeat (5) @(posedge wb_clk_i);
                #1 chk("flush_stb_low", ns - s0, 0);
                push(32'h55AA_55AA, 4'hC);
            end
        join
        chk("post_rst_adr", b_adr[b0], 8'h40);
        chk("post_rst_data", {b_sel[b0], b_dat[b0]}, {4'hC, 32'h55AA_55AA});
        chk("post_rst_err", done_err, 0);
`ifdef PERIPHERAL_SPRAM_WB_MASTER_ERR_EN
        // error on beat 2 of a prefilled write
        for (int k = 0; k < 4; k++) push(32'h6000_0000 + 32'(k), 4'hF);
        b0 = nb;
        err_at = 1;
        issue(1'b1, 8'h80, 4'd3);
        err_at = -1;
        chk("err_flag", done_err, 1);
        chk("err_nbeat", nb - b0, 1);
        chk("err_done_at", done_cyc - t_acc, 4);
        b0 = nb; s0 = ns;
        fork
            issue(1'b1, 8'h84, 4'd0);
            begin
                repeat (5) @(posedge wb_clk_i);
                #1 chk("err_fifo_empty", ns - s0, 0);
                push(32'h7777_7777, 4'hF);
            end
        join
        chk("err_next_data", b_dat[b0], 32'h7777_7777);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
